// File: rtl/gate_exerciser_pkg.sv
// Shared definitions for the two-input gate exerciser: gate codes, FSM states,
// the fixed stimulus table and a reference gate evaluator.
package gate_exerciser_pkg;

  localparam logic [1:0] GATE_AND  = 2'd0;
  localparam logic [1:0] GATE_OR   = 2'd1;
  localparam logic [1:0] GATE_XOR  = 2'd2;
  localparam logic [1:0] GATE_NAND = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  localparam int NUM_VEC = 5;
  // Entry 0 sits in the low bits; each entry is {in1,in2}.
  localparam logic [NUM_VEC-1:0][1:0] VEC_TABLE = {2'b00, 2'b11, 2'b10, 2'b01, 2'b00};

  function automatic logic gate_eval(input logic [1:0] fn, input logic a, input logic b);
    case (fn)
      GATE_AND:  return a & b;
      GATE_OR:   return a | b;
      GATE_XOR:  return a ^ b;
      default:   return ~(a & b);
    endcase
  endfunction

endpackage

// File: rtl/gate_exerciser_hold_timer.sv
// Per-vector hold counter: counts 0..HOLD_CYCLES-1 while enabled and wraps,
// flagging the last cycle of each hold window.
module gate_exerciser_hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] cnt_q;

  assign tc_o = (cnt_q == 8'(HOLD_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || clr_i)
      cnt_q <= '0;
    else if (en_i)
      cnt_q <= tc_o ? 8'd0 : cnt_q + 8'd1;
  end

endmodule

// File: rtl/gate_exerciser.sv
// Drives a fixed five-vector sequence into a two-input gate, checks each
// response against the expected function and reports a saturating error count.
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [1:0] GATE_FN     = 2'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  input  logic       out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count
);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [1:0] vec_q, vec_d;
  logic [2:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       launch_q, launch_d;
  logic       tc;

  gate_exerciser_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clock (clock),
    .reset (reset),
    .clr_i (launch_q),
    .en_i  (state_q == S_DRIVE),
    .tc_o  (tc)
  );

  // A sampled start arms launch_q; the run itself begins one edge later.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      vec_q    <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      launch_q <= launch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    vec_d    = vec_q;
    err_d    = err_q;
    pass_d   = pass_q;
    launch_d = 1'b0;
    if (launch_q) begin
      state_d = S_DRIVE;
      idx_d   = '0;
      vec_d   = VEC_TABLE[0];
      err_d   = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: launch_d = start;
        S_DRIVE: begin
          if (tc) begin
            if ((out != gate_eval(GATE_FN, vec_q[1], vec_q[0])) && (err_q != 3'd7))
              err_d = err_q + 3'd1;
            if (idx_q == 3'(NUM_VEC - 1)) begin
              state_d = S_DONE;
              vec_d   = 2'b00;
              pass_d  = (err_d == 3'd0);
            end else begin
              idx_d = idx_q + 3'd1;
              vec_d = VEC_TABLE[idx_d];
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign in1       = vec_q[1];
  assign in2       = vec_q[0];
  assign busy      = (state_q == S_DRIVE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: an OR/10-cycle instance and an AND/2-cycle
// instance, exercised by table-driven runs, corner sequences and random responses.
module tb_gate_exerciser;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic sel   = 1'b0;
  int   omode = 0;
  logic rnd   = 1'b0;

  logic a_in1, a_in2, a_busy, a_done, a_pass, a_out;
  logic b_in1, b_in2, b_busy, b_done, b_pass, b_out;
  logic [2:0] a_err, b_err;
  logic in1_w, in2_w, busy_w, done_w, pass_w, out_w;
  logic [2:0] err_w;

  int total = 0;
  int bad   = 0;

  logic [1:0] VEC [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

  always #5 clock = ~clock;

  gate_exerciser #(.HOLD_CYCLES(10), .GATE_FN(2'd1)) dut_or (
    .clock(clock), .reset(reset), .start(start & ~sel), .in1(a_in1), .in2(a_in2),
    .out(a_out), .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err));

  gate_exerciser #(.HOLD_CYCLES(2), .GATE_FN(2'd0)) dut_and (
    .clock(clock), .reset(reset), .start(start & sel), .in1(b_in1), .in2(b_in2),
    .out(b_out), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err));

  function automatic logic gate_ref(input int g, input logic a, input logic b);
    case (g)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Gate-under-test model: 0 correct gate, 1 stuck at 0, 2 stuck at 1, 3 random.
  always_comb begin
    in1_w  = sel ? b_in1  : a_in1;
    in2_w  = sel ? b_in2  : a_in2;
    busy_w = sel ? b_busy : a_busy;
    done_w = sel ? b_done : a_done;
    pass_w = sel ? b_pass : a_pass;
    err_w  = sel ? b_err  : a_err;
    case (omode)
      0: out_w = gate_ref(sel ? 0 : 1, in1_w, in2_w);
      1: out_w = 1'b0;
      2: out_w = 1'b1;
      default: out_w = rnd;
    endcase
    a_out = sel ? 1'b0 : out_w;
    b_out = sel ? out_w : 1'b0;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    check({nm, " busy"}, busy_w, 0);
    check({nm, " done"}, done_w, 0);
    check({nm, " pass"}, pass_w, 0);
    check({nm, " err"}, err_w, 0);
    check({nm, " vec"}, {in1_w, in2_w}, 0);
  endtask

  // One full run from IDLE/DONE; the model predicts every vector, the
  // completion time and the final count from the table and the observed response.
  task automatic do_run(input int mode, input bit hold_start, input int pulse_at,
                        output int err_o, output bit pass_o);
    int H, G, exp_err;
    logic [1:0] ev;
    H = sel ? 2 : 10;
    G = sel ? 0 : 1;
    omode = mode;
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    tick();
    check("launch busy", busy_w, 1);
    check("launch done", done_w, 0);
    check("launch err", err_w, 0);
    check("launch vec", {in1_w, in2_w}, 0);
    exp_err = 0;
    for (int e = 1; e <= 5 * H; e++) begin
      if (e == pulse_at) start = 1'b1;
      else if (!hold_start) start = 1'b0;
      rnd = 1'($urandom_range(0, 1));
      #1;
      if (e % H == 0) begin
        ev = VEC[e / H - 1];
        if (out_w != gate_ref(G, ev[1], ev[0])) exp_err = (exp_err < 7) ? exp_err + 1 : 7;
      end
      tick();
      if (e < 5 * H) begin
        ev = VEC[e / H];
        if ((e % H == 0) || e == 1) begin
          check("drive vec", {in1_w, in2_w}, ev);
          check("drive err", err_w, exp_err);
        end
        if (done_w || !busy_w) check("drive busy/done", {busy_w, done_w}, 2'b10);
      end
    end
    check("end done", done_w, 1);
    check("end busy", busy_w, 0);
    check("end vec", {in1_w, in2_w}, 0);
    check("end err", err_w, exp_err);
    check("end pass", pass_w, (exp_err == 0));
    err_o  = err_w;
    pass_o = pass_w;
  endtask

  typedef struct {
    logic sel;
    int   mode;
    int   exp_err;
    bit   exp_pass;
  } run_vec_t;

  initial begin
    run_vec_t tbl[6];
    int eo;
    bit po;

    tbl[0] = '{1'b0, 0, 0, 1'b1};  // OR, correct gate
    tbl[1] = '{1'b0, 1, 3, 1'b0};  // OR, stuck 0: 01,10,11
    tbl[2] = '{1'b1, 2, 4, 1'b0};  // AND, stuck 1: 00,01,10,00
    tbl[3] = '{1'b1, 0, 0, 1'b1};  // AND, correct gate
    tbl[4] = '{1'b0, 2, 2, 1'b0};  // OR, stuck 1: both 00
    tbl[5] = '{1'b1, 1, 1, 1'b0};  // AND, stuck 0: 11 only

    tick();
    tick();
    sel = 1'b0; check_idle("reset or");
    sel = 1'b1; check_idle("reset and");
    reset = 1'b0;
    tick();
    sel = 1'b0; check_idle("idle or");

    for (int i = 0; i < 6; i++) begin
      sel = tbl[i].sel;
      do_run(tbl[i].mode, 1'b0, 0, eo, po);
      check($sformatf("tbl%0d err", i), eo, tbl[i].exp_err);
      check($sformatf("tbl%0d pass", i), po, tbl[i].exp_pass);
    end

    // DONE holds its outputs while start stays low.
    sel = 1'b0;
    do_run(1, 1'b0, 0, eo, po);
    for (int i = 0; i < 3; i++) tick();
    check("hold done", done_w, 1);
    check("hold err", err_w, 3);
    check("hold pass", pass_w, 0);
    check("hold busy", busy_w, 0);

    // Start pulse during DRIVE is ignored; timing is checked inside the run.
    do_run(0, 1'b0, 20, eo, po);
    check("pulse pass", po, 1);

    // Reset 25 cycles into a run, then a clean full run.
    omode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 24; i++) tick();
    check("pre-reset busy", busy_w, 1);
    check("pre-reset err", err_w, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("midreset");
    tick();
    check_idle("post-reset idle");
    do_run(0, 1'b0, 0, eo, po);
    check("after reset pass", po, 1);

    // Start held high: relaunch right after DONE entry with a cleared count.
    do_run(1, 1'b1, 0, eo, po);
    tick();
    check("relaunch done still", done_w, 1);
    check("relaunch err still", err_w, 3);
    tick();
    check("relaunch busy", busy_w, 1);
    check("relaunch done", done_w, 0);
    check("relaunch err", err_w, 0);
    check("relaunch pass", pass_w, 0);

    // Reset wins over start on the same edge.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check_idle("reset prio");
    tick();
    tick();
    check("reset prio stays idle", busy_w, 0);

    // Random gate responses against the model.
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom_range(0, 1));
      do_run(3, 1'b0, 0, eo, po);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
